etapa_wb: RTL and testbench

ETAPA_WB -- requirements
Module: etapa_WB

---
 rtl/etapa_wb_pkg.sv | 39 +++
 rtl/etapa_wb_banco_registros.sv | 48 ++++
 rtl/etapa_wb.sv | 89 ++++++++
 tb/tb_etapa_wb.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/etapa_wb_pkg.sv
// rtl/etapa_wb_pkg.sv - shared write-back encodings, widths and value selection
package etapa_wb_pkg;

    localparam int DATA_W = 32;
    localparam int NREG   = 8;
    localparam int ADDR_W = 3;
    localparam int IMM_W  = 8;

    typedef enum logic [1:0] {
        WB_DATA = 2'b00,
        WB_MEM  = 2'b01,
        WB_IMMZ = 2'b10,
        WB_IMMS = 2'b11
    } sel_wb_e;

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic [ADDR_W-1:0] dir;
        logic [DATA_W-1:0] value;
    } wb_latch_t;

    function automatic logic [DATA_W-1:0] wb_select(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] data,
        input logic [DATA_W-1:0] mem,
        input logic [IMM_W-1:0]  imm
    );
        logic [DATA_W-1:0] res;
        case (sel_wb_e'(sel))
            WB_DATA: res = data;
            WB_MEM:  res = mem;
            WB_IMMZ: res = {{(DATA_W-IMM_W){1'b0}}, imm};
            default: res = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/etapa_wb_banco_registros.sv
// rtl/etapa_wb_banco_registros.sv - register file, one write port, two read ports, r0 hardwired to zero
module banco_registros
    import etapa_wb_pkg::*;
#(
    parameter int NREG = etapa_wb_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic              wr_ok;

    // Index 0 and any index past the array are silently dropped
    assign wr_ok = we_i && (waddr_i != '0) && (int'(waddr_i) < NREG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        if ((raddr_a_i != '0) && (int'(raddr_a_i) < NREG)) begin
            rdata_a_o = regs_q[raddr_a_i];
        end
    end

    always_comb begin
        rdata_b_o = '0;
        if ((raddr_b_i != '0) && (int'(raddr_b_i) < NREG)) begin
            rdata_b_o = regs_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/etapa_wb.sv
// rtl/etapa_wb.sv - write-back stage: result latch, register file write, read bypass, retire counter
module etapa_wb
    import etapa_wb_pkg::*;
#(
    parameter int NREG = etapa_wb_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [IMM_W-1:0]  inmediate_in,
    input  logic [ADDR_W-1:0] dir_dest_in,
    input  logic              wb_en_in,
    input  logic [1:0]        sel_wb,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_dir,
    output logic [DATA_W-1:0] wb_value,
    output logic [15:0]       retired
);

    wb_latch_t         latch_q, latch_d;
    logic [15:0]       retired_q, retired_d;
    logic              wr_en;
    logic [DATA_W-1:0] arr_a, arr_b;

    always_comb begin
        latch_d = latch_q;
        if (flush) begin
            latch_d.valid = 1'b0;
        end else if (!stall) begin
            latch_d.valid = valid_in;
            latch_d.wb_en = wb_en_in;
            latch_d.dir   = dir_dest_in;
            latch_d.value = wb_select(sel_wb, data_in, mem_in, inmediate_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_q   <= '0;
            retired_q <= '0;
        end else begin
            latch_q   <= latch_d;
            retired_q <= retired_d;
        end
    end

    assign wb_valid  = latch_q.valid && latch_q.wb_en && (latch_q.dir != '0);
    assign wb_dir    = latch_q.dir;
    assign wb_value  = latch_q.value;
    assign retired   = retired_q;

    // A stalled entry stays put and commits on the first edge where stall and flush are both low
    assign wr_en     = wb_valid && !stall && !flush;
    assign retired_d = wr_en ? retired_q + 16'd1 : retired_q;

    banco_registros #(
        .NREG (NREG)
    ) u_banco (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (wr_en),
        .waddr_i   (latch_q.dir),
        .wdata_i   (latch_q.value),
        .raddr_a_i (rd_addr_a),
        .rdata_a_o (arr_a),
        .raddr_b_i (rd_addr_b),
        .rdata_b_o (arr_b)
    );

    always_comb begin
        rd_data_a = arr_a;
        rd_data_b = arr_b;
        if (wb_valid && !stall && (rd_addr_a == latch_q.dir)) begin
            rd_data_a = latch_q.value;
        end
        if (wb_valid && !stall && (rd_addr_b == latch_q.dir)) begin
            rd_data_b = latch_q.value;
        end
    end

endmodule

// File: tb/tb_etapa_wb.sv
// tb/tb_etapa_wb.sv - directed self-checking bench for etapa_wb
module tb_etapa_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, stall, flush, wb_en_in;
    logic [31:0] mem_in, data_in;
    logic [7:0]  inmediate_in;
    logic [2:0]  dir_dest_in, rd_addr_a, rd_addr_b;
    logic [1:0]  sel_wb;
    logic [31:0] rd_data_a, rd_data_b, wb_value;
    logic        wb_valid;
    logic [2:0]  wb_dir;
    logic [15:0] retired;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    etapa_wb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .stall        (stall),
        .flush        (flush),
        .mem_in       (mem_in),
        .data_in      (data_in),
        .inmediate_in (inmediate_in),
        .dir_dest_in  (dir_dest_in),
        .wb_en_in     (wb_en_in),
        .sel_wb       (sel_wb),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .wb_valid     (wb_valid),
        .wb_dir       (wb_dir),
        .wb_value     (wb_value),
        .retired      (retired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input logic [2:0] dir, input logic [31:0] dat,
                        input logic [31:0] mem, input logic [7:0] imm, input logic en);
        valid_in     = 1'b1;
        sel_wb       = sel;
        dir_dest_in  = dir;
        data_in      = dat;
        mem_in       = mem;
        inmediate_in = imm;
        wb_en_in     = en;
        tick();
        valid_in     = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 0; stall = 0; flush = 0; wb_en_in = 0;
        mem_in = 0; data_in = 0; inmediate_in = 0; dir_dest_in = 0; sel_wb = 0;
        rd_addr_a = 0; rd_addr_b = 0;
        tick();
        check("rst_retired", {16'd0, retired}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_value", wb_value, 32'd0);
        rst_n = 1'b1;

        // mem select into r3, with bypass visible while latched
        rd_addr_a = 3;
        load(2'b01, 3'd3, 32'h1111_1111, 32'hDEAD_BEEF, 8'h00, 1'b1);
        check("mem_wb_value", wb_value, 32'hDEAD_BEEF);
        check("mem_wb_dir", {29'd0, wb_dir}, 32'd3);
        check("mem_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("mem_bypass_a", rd_data_a, 32'hDEAD_BEEF);
        tick();
        check("mem_r3_array", rd_data_a, 32'hDEAD_BEEF);
        check("mem_retired", {16'd0, retired}, 32'd1);

        // immediate sign- then zero-extended into r5
        rd_addr_b = 5;
        load(2'b11, 3'd5, 32'h0, 32'h0, 8'h80, 1'b1);
        tick();
        check("imms_r5", rd_data_b, 32'hFFFF_FF80);
        load(2'b10, 3'd5, 32'h0, 32'h0, 8'h80, 1'b1);
        tick();
        check("immz_r5", rd_data_b, 32'h0000_0080);
        rd_addr_b = 7;
        load(2'b00, 3'd7, 32'hCAFE_F00D, 32'h0, 8'h7F, 1'b1);
        tick();
        check("data_r7", rd_data_b, 32'hCAFE_F00D);
        check("data_retired", {16'd0, retired}, 32'd4);

        // stall holds a pending write to r2 for three edges
        rd_addr_a = 2;
        load(2'b00, 3'd2, 32'hA5A5_A5A5, 32'h0, 8'h00, 1'b1);
        stall = 1'b1;
        #1;
        check("stall_no_bypass", rd_data_a, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        check("stall_retired", {16'd0, retired}, 32'd4);
        check("stall_r2_old", rd_data_a, 32'h0);
        check("stall_held_valid", {31'd0, wb_valid}, 32'd1);
        stall = 1'b0;
        #1;
        check("unstall_bypass", rd_data_a, 32'hA5A5_A5A5);
        tick();
        check("unstall_r2", rd_data_a, 32'hA5A5_A5A5);
        check("unstall_retired", {16'd0, retired}, 32'd5);
        tick();
        check("unstall_once", {16'd0, retired}, 32'd5);

        // flush beats stall for a pending write to r4
        rd_addr_a = 4;
        load(2'b00, 3'd4, 32'h4444_4444, 32'h0, 8'h00, 1'b1);
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        #1;
        check("flush_valid", {31'd0, wb_valid}, 32'd0);
        tick();
        check("flush_r4", rd_data_a, 32'h0);
        check("flush_retired", {16'd0, retired}, 32'd5);

        // same-cycle bypass on r6, then a dropped write to r0
        rd_addr_a = 6;
        load(2'b00, 3'd6, 32'h1234_5678, 32'h0, 8'h00, 1'b1);
        check("bypass_r6", rd_data_a, 32'h1234_5678);
        tick();
        rd_addr_a = 0;
        load(2'b00, 3'd0, 32'hFFFF_FFFF, 32'h0, 8'h00, 1'b1);
        check("r0_wb_valid", {31'd0, wb_valid}, 32'd0);
        tick();
        check("r0_reads_zero", rd_data_a, 32'h0);
        check("r0_retired", {16'd0, retired}, 32'd6);

        // wb_en low must not write
        rd_addr_a = 1;
        load(2'b00, 3'd1, 32'h5555_5555, 32'h0, 8'h00, 1'b0);
        tick();
        check("noen_r1", rd_data_a, 32'h0);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        rd_addr_a = 6;
        #1;
        check("arst_retired", {16'd0, retired}, 32'd0);
        check("arst_r6", rd_data_a, 32'h0);
        check("arst_wb_dir", {29'd0, wb_dir}, 32'd0);
        tick();
        rst_n = 1'b1;

        // retired wrap: 65535 writes then one more
        valid_in = 1'b1; wb_en_in = 1'b1; sel_wb = 2'b00; dir_dest_in = 3'd1;
        for (int i = 0; i < 65535; i++) begin
            data_in = i;
            tick();
        end
        valid_in = 1'b0;
        tick();
        check("wrap_ffff", {16'd0, retired}, 32'h0000_FFFF);
        load(2'b00, 3'd1, 32'h0, 32'h0, 8'h00, 1'b1);
        tick();
        check("wrap_zero", {16'd0, retired}, 32'h0);

        // reset mid-stall with a latched entry
        load(2'b01, 3'd2, 32'h0, 32'h7777_7777, 8'h00, 1'b1);
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stall_valid", {31'd0, wb_valid}, 32'd0);
        check("arst_stall_value", wb_value, 32'h0);
        stall = 1'b0;
        tick();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
